// File: rtl/sr_mon_pkg.sv
// sr_mon_pkg: shared state encodings and default counter width for the SR flip-flop monitor
package sr_mon_pkg;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    TRACK   = 2'd1,
    HALT    = 2'd2
  } mon_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its all-ones value instead of wrapping
module sat_counter
  import sr_mon_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor: checks an observed SR flip-flop's Q/Qbar against the behaviour implied by its S/R inputs
module sr_ff_monitor
  import sr_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qbar,
  output logic             mismatch,
  output logic             illegal,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic             exp_valid,
  output logic [1:0]       state
);
  mon_state_t st, st_d;
  logic exp_q, exp_d, fail, ill, sets, ill_cnt;
  always_comb begin
    ill = S & R;
    sets = S ^ R;
    fail = (st == TRACK) && ((Q != exp_q) || (Qbar == Q));
    ill_cnt = ill && (st != HALT);
    st_d = st;
    exp_d = exp_q;
    // a 00 sample keeps the expectation; a check failure never rewrites it
    case (st)
      UNKNOWN: begin
        st_d = sets ? TRACK : UNKNOWN;
        exp_d = sets ? S : exp_q;
      end
      TRACK: begin
        st_d = (fail && STOP_ON_ERR) ? HALT : ill ? UNKNOWN : TRACK;
        exp_d = sets ? S : exp_q;
      end
      default: st_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= UNKNOWN;
      exp_q <= 1'b0;
      mismatch <= 1'b0;
      illegal <= 1'b0;
    end else begin
      st <= st_d;
      exp_q <= exp_d;
      mismatch <= fail;
      illegal <= ill;
    end
  sat_counter #(.W(CNT_W)) u_err (.clk(clk), .rst_n(rst_n), .inc(fail), .count(err_count));
  sat_counter #(.W(CNT_W)) u_ill (.clk(clk), .rst_n(rst_n), .inc(ill_cnt), .count(illegal_count));
  assign exp_valid = (st == TRACK);
  assign state = st;
endmodule

// File: tb/tb_sr_ff_monitor.sv
// tb_sr_ff_monitor: three monitor configurations driven in parallel, checked against a behavioural model
module tb_sr_ff_monitor;
  logic clk = 1'b0;
  logic rst_n;
  logic S = 1'b0, R = 1'b0, Q = 1'b0, Qbar = 1'b1;
  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] mis_v, il_v, ev_v;
  logic [1:0] st_v [3];
  logic [7:0] ec_v [3], ic_v [3];
  logic [1:0] ec2, ic2;

  sr_ff_monitor u_d0 (.clk(clk), .rst_n(rst_n), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .mismatch(mis_v[0]), .illegal(il_v[0]), .err_count(ec_v[0]), .illegal_count(ic_v[0]),
    .exp_valid(ev_v[0]), .state(st_v[0]));
  sr_ff_monitor #(.CNT_W(2)) u_d2 (.clk(clk), .rst_n(rst_n), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .mismatch(mis_v[1]), .illegal(il_v[1]), .err_count(ec2), .illegal_count(ic2),
    .exp_valid(ev_v[1]), .state(st_v[1]));
  sr_ff_monitor #(.STOP_ON_ERR(1'b1)) u_dh (.clk(clk), .rst_n(rst_n), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .mismatch(mis_v[2]), .illegal(il_v[2]), .err_count(ec_v[2]), .illegal_count(ic_v[2]),
    .exp_valid(ev_v[2]), .state(st_v[2]));
  assign ec_v[1] = {6'd0, ec2};
  assign ic_v[1] = {6'd0, ic2};

  // model: "known" means a set or reset has been seen since the last reset/illegal input
  int  m_err [3] = '{0, 0, 0};
  int  m_ill [3] = '{0, 0, 0};
  bit  m_mis [3] = '{0, 0, 0};
  bit  m_il  [3] = '{0, 0, 0};
  bit  m_known [3] = '{0, 0, 0};
  bit  m_halt [3] = '{0, 0, 0};
  bit  m_exp [3] = '{0, 0, 0};
  int  m_max [3] = '{255, 3, 255};
  bit  m_stop [3] = '{0, 0, 1};

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_err[k] = 0; m_ill[k] = 0; m_mis[k] = 0; m_il[k] = 0;
        m_known[k] = 0; m_halt[k] = 0; m_exp[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit live, wrong, both;
        live = m_known[k] && !m_halt[k];
        wrong = live && ((Q != m_exp[k]) || (Qbar == Q));
        both = S && R;
        m_mis[k] = wrong;
        m_il[k] = both;
        if (wrong) m_err[k] = (m_err[k] + 1 > m_max[k]) ? m_max[k] : m_err[k] + 1;
        if (both && !m_halt[k]) m_ill[k] = (m_ill[k] + 1 > m_max[k]) ? m_max[k] : m_ill[k] + 1;
        if (wrong && m_stop[k]) m_halt[k] = 1;
        else if (!m_halt[k]) begin
          if (both) m_known[k] = 0;
          else if (S != R) begin m_known[k] = 1; m_exp[k] = S; end
        end
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (cmp_en)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d.mismatch", k), 32'(mis_v[k]), 32'(m_mis[k]));
        chk($sformatf("m%0d.illegal", k), 32'(il_v[k]), 32'(m_il[k]));
        chk($sformatf("m%0d.err_count", k), 32'(ec_v[k]), m_err[k]);
        chk($sformatf("m%0d.illegal_count", k), 32'(ic_v[k]), m_ill[k]);
        chk($sformatf("m%0d.exp_valid", k), 32'(ev_v[k]), 32'(m_known[k] && !m_halt[k]));
        chk($sformatf("m%0d.state", k), 32'(st_v[k]), m_halt[k] ? 2 : m_known[k] ? 1 : 0);
      end

  task automatic step(input logic s, input logic r, input logic q, input logic qb);
    @(negedge clk);
    #2;
    S = s; R = r; Q = q; Qbar = qb;
    @(posedge clk);
    #1;
  endtask

  task automatic pin_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".mis"}, 32'(mis_v[k]), 0);
      chk({tag, ".ill"}, 32'(il_v[k]), 0);
      chk({tag, ".ec"}, 32'(ec_v[k]), 0);
      chk({tag, ".ic"}, 32'(ic_v[k]), 0);
      chk({tag, ".ev"}, 32'(ev_v[k]), 0);
      chk({tag, ".st"}, 32'(st_v[k]), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #23;
    pin_zero("reset");
    cmp_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("set_track.st", 32'(st_v[0]), 1);
    chk("set_track.mis", 32'(mis_v[0]), 0);
    chk("set_track.ec", 32'(ec_v[0]), 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    chk("reset_stuck.mis", 32'(mis_v[0]), 1);
    chk("reset_stuck.ec", 32'(ec_v[0]), 1);
    chk("halt.st", 32'(st_v[2]), 2);
    chk("halt.ev", 32'(ev_v[2]), 0);
    step(0, 0, 0, 1);
    chk("recover.mis", 32'(mis_v[0]), 0);
    step(1, 1, 0, 1);
    chk("illegal.pulse", 32'(il_v[0]), 1);
    chk("illegal.ic", 32'(ic_v[0]), 1);
    chk("illegal.st", 32'(st_v[0]), 0);
    chk("illegal.ev", 32'(ev_v[0]), 0);
    chk("halt_illegal.pulse", 32'(il_v[2]), 1);
    chk("halt_illegal.ic", 32'(ic_v[2]), 0);
    step(0, 0, 1, 1);
    chk("after_illegal.mis", 32'(mis_v[0]), 0);
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("qbar_only.mis", 32'(mis_v[0]), 1);
    chk("qbar_only.ec", 32'(ec_v[0]), 2);
    chk("halt_fault.mis", 32'(mis_v[2]), 0);
    step(0, 0, 1, 0);
    chk("qbar_ok.mis", 32'(mis_v[0]), 0);
    repeat (3) step(0, 0, 0, 0);
    chk("both_fail.ec", 32'(ec_v[0]), 5);
    chk("sat.ec", 32'(ec_v[1]), 3);
    chk("halt_frozen.ec", 32'(ec_v[2]), 1);
    step(0, 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0; S = 1'b0; R = 1'b0; Q = 1'b0; Qbar = 1'b0;
    #1 pin_zero("midreset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("post_reset.mis", 32'(mis_v[0]), 0);
    chk("post_reset.st", 32'(st_v[0]), 0);
    repeat (4) step(1, 1, 0, 1);
    chk("ill_count.ic", 32'(ic_v[0]), 4);
    chk("ill_sat.ic", 32'(ic_v[1]), 3);
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    chk("combo.mis", 32'(mis_v[0]), 1);
    chk("combo.ill", 32'(il_v[0]), 1);
    chk("combo.st", 32'(st_v[0]), 0);
    chk("combo_halt.st", 32'(st_v[2]), 2);
    chk("combo_halt.ic", 32'(ic_v[2]), 5);
    step(0, 0, 1, 1);
    chk("combo_after.mis", 32'(mis_v[0]), 0);
    chk("combo_after_halt.mis", 32'(mis_v[2]), 0);
    step(0, 0, 0, 1);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
